// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares the single data-memory port between the CPU M-stage
// load/store path and a secondary device master (UART loader / debug DMA).
// Each transfer goes IDLE (arbitrate) -> ISSUE (mem_en) -> [WAIT] -> RESP (ack).
// CPU has priority; after STARVE_MAX consecutive CPU wins over a pending
// device request, the device is forced to win.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   cpu_req/byteen/addr/wdata/flush CPU request side (byteen == 0 -> read)
//   cpu_rdata, cpu_ack, cpu_stall   CPU response and pipeline freeze
//   dev_req/byteen/addr/wdata       device request side
//   dev_rdata, dev_ack              device response
//   mem_en/byteen/addr/wdata        registered memory request
//   mem_rdata                       memory read data, RD_LAT cycles after mem_en
//   busy, owner                     transfer in progress / 0=CPU, 1=device
module dm_bus_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dev_req,
  input  logic [3:0]  dev_byteen,
  input  logic [31:0] dev_addr,
  input  logic [31:0] dev_wdata,
  output logic [31:0] dev_rdata,
  output logic        dev_ack,
  output logic        mem_en,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_INIT_C  = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  mem_byteen_q, mem_byteen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        owner_q, owner_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dev_rdata_q, dev_rdata_d;

  logic cand_cpu, cand_dev, dev_win, cpu_win;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_byteen_d = mem_byteen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dev_rdata_d  = dev_rdata_q;

    cand_cpu = cpu_req & ~cpu_flush;
    cand_dev = dev_req;
    dev_win  = cand_dev & (~cand_cpu | (starve_cnt_q == STARVE_MAX_C));
    cpu_win  = cand_cpu & ~dev_win;

    unique case (state_q)
      IDLE: begin
        if (dev_win) begin
          mem_byteen_d = dev_byteen;
          mem_addr_d   = dev_addr;
          mem_wdata_d  = dev_wdata;
          owner_d      = 1'b1;
          state_d      = ISSUE;
        end else if (cpu_win) begin
          mem_byteen_d = cpu_byteen;
          mem_addr_d   = cpu_addr;
          mem_wdata_d  = cpu_wdata;
          owner_d      = 1'b0;
          state_d      = ISSUE;
        end
        // Counts CPU wins only while the device is actually waiting.
        if (cpu_win && cand_dev) begin
          if (starve_cnt_q != STARVE_MAX_C) starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ISSUE: begin
        if (mem_byteen_q != '0) begin
          state_d = RESP;
        end else begin
          wait_cnt_d = WAIT_INIT_C;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          if (owner_q) dev_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_byteen_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      owner_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      dev_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_byteen_q <= mem_byteen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      owner_q      <= owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dev_rdata_q  <= dev_rdata_d;
    end
  end

  // Strobes decode straight from the state register so reset removes them
  // without waiting for a clock edge.
  assign mem_en     = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign cpu_ack    = (state_q == RESP) & ~owner_q;
  assign dev_ack    = (state_q == RESP) &  owner_q;
  assign cpu_stall  = cpu_req & ~cpu_ack & ~cpu_flush;
  assign owner      = owner_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dev_rdata  = dev_rdata_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: table-driven single transfers,
// a memory-side scoreboard of expected mem_en transactions, and hand-written
// sequences for starvation, flush and mid-transfer reset.
module tb_dm_bus_arbiter;

  localparam int unsigned RD_LAT     = 3;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk, reset;
  logic        cpu_req, cpu_flush, cpu_ack, cpu_stall;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dev_req, dev_ack;
  logic [3:0]  dev_byteen;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic        mem_en, busy, owner;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dm_bus_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_byteen(cpu_byteen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dev_req(dev_req), .dev_byteen(dev_byteen), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .mem_en(mem_en), .mem_byteen(mem_byteen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  bit   [31:0] memory [bit [29:0]];
  logic [31:0] pipe [RD_LAT];
  logic [31:0] mm_word;
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    mm_word = memory.exists(mem_addr[31:2]) ? memory[mem_addr[31:2]] : 32'h0;
    if (mem_en && mem_byteen != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mm_word[8*b +: 8] = mem_wdata[8*b +: 8];
      memory[mem_addr[31:2]] = mm_word;
    end
    pipe[0] <= (mem_en && mem_byteen == 4'b0000) ? mm_word : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // ---------------- memory-side scoreboard ----------------
  typedef struct packed {
    logic        own;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;
  xfer_t sb_q[$];
  xfer_t sb_exp;

  always @(negedge clk) begin
    if (!reset && mem_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got mem_en addr %h required no transfer", mem_addr);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_owner",  {31'b0, owner}, {31'b0, sb_exp.own});
        check("sb_byteen", {28'b0, mem_byteen}, {28'b0, sb_exp.be});
        check("sb_addr",   mem_addr, sb_exp.addr);
        check("sb_wdata",  mem_wdata, sb_exp.wdata);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          dev;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  logic [31:0] mdl_cpu_rdata = '0;
  logic [31:0] mdl_dev_rdata = '0;

  task automatic do_xfer(input vec_t v, input string tag);
    int cyc;
    sb_q.push_back({v.dev, v.be, v.addr, v.wdata});
    if (v.dev) begin
      dev_req = 1'b1; dev_byteen = v.be; dev_addr = v.addr; dev_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_byteen = v.be; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    #1;
    if (!v.dev) check({tag, "_stall_c1"}, {31'b0, cpu_stall}, 32'd1);
    cyc = 1;
    while (!(v.dev ? dev_ack : cpu_ack) && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, v.lat);
    if (v.be == 4'b0000) begin
      if (v.dev) mdl_dev_rdata = v.rdata;
      else       mdl_cpu_rdata = v.rdata;
    end
    check({tag, "_cpu_rdata"}, cpu_rdata, mdl_cpu_rdata);
    check({tag, "_dev_rdata"}, dev_rdata, mdl_dev_rdata);
    if (!v.dev) check({tag, "_stall_ack"}, {31'b0, cpu_stall}, 32'd0);
    tick();
    cpu_req = 1'b0;
    dev_req = 1'b0;
  endtask

  bit ord[6];
  int n, cyc;

  initial begin
    vecs[0] = '{1'b0, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 3};
    vecs[1] = '{1'b0, 4'b0000, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[2] = '{1'b1, 4'b1111, 32'h0000_2000, 32'hAAAA_AAAA, 32'h0, 3};
    vecs[3] = '{1'b0, 4'b0011, 32'h0000_2000, 32'h1111_2222, 32'h0, 3};
    vecs[4] = '{1'b1, 4'b0000, 32'h0000_2000, 32'h0,         32'hAAAA_2222, 6};
    vecs[5] = '{1'b1, 4'b1100, 32'h0000_1004, 32'h5566_7788, 32'h0, 3};
    vecs[6] = '{1'b0, 4'b0000, 32'h0000_1004, 32'h0,         32'h5566_BEEF, 6};
    vecs[7] = '{1'b1, 4'b1000, 32'hFFFF_FFFC, 32'h7F00_0000, 32'h0, 3};
    vecs[8] = '{1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0,         32'h7F00_0000, 6};
    vecs[9] = '{1'b1, 4'b0000, 32'h0000_3000, 32'h0,         32'h0, 6};

    reset = 1'b1;
    cpu_req = 0; cpu_byteen = '0; cpu_addr = '0; cpu_wdata = '0; cpu_flush = 0;
    dev_req = 0; dev_byteen = '0; dev_addr = '0; dev_wdata = '0;
    tick();
    tick();
    check("rst_busy",      {31'b0, busy}, 32'd0);
    check("rst_mem_en",    {31'b0, mem_en}, 32'd0);
    check("rst_acks",      {30'b0, cpu_ack, dev_ack}, 32'd0);
    check("rst_owner",     {31'b0, owner}, 32'd0);
    check("rst_stall",     {31'b0, cpu_stall}, 32'd0);
    check("rst_mem_byteen", {28'b0, mem_byteen}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dev_rdata", dev_rdata, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_xfer(vecs[i], $sformatf("row%0d", i));

    // Starvation guard: both held, writes only.
    ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++)
      sb_q.push_back(ord[i] ? {1'b1, 4'b1111, 32'h0000_5000, 32'hD0D0_0001}
                            : {1'b0, 4'b1111, 32'h0000_4000, 32'hC0C0_0001});
    cpu_req = 1; cpu_byteen = 4'b1111; cpu_addr = 32'h0000_4000; cpu_wdata = 32'hC0C0_0001;
    dev_req = 1; dev_byteen = 4'b1111; dev_addr = 32'h0000_5000; dev_wdata = 32'hD0D0_0001;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      if (cpu_ack || dev_ack) begin
        check($sformatf("starve_ack%0d_is_dev", n), {31'b0, dev_ack}, {31'b0, ord[n]});
        n++;
      end
      tick();
      cyc++;
    end
    cpu_req = 0; dev_req = 0;
    check("starve_ack_count", n, 6);
    tick();

    // Simultaneous requests under flush: device first, no stall.
    sb_q.push_back({1'b1, 4'b1111, 32'h0000_6000, 32'h600D_600D});
    cpu_req = 1; cpu_byteen = 4'b1111; cpu_addr = 32'h0000_7000; cpu_wdata = 32'h7777_0000;
    dev_req = 1; dev_byteen = 4'b1111; dev_addr = 32'h0000_6000; dev_wdata = 32'h600D_600D;
    cpu_flush = 1;
    #1;
    check("flush_stall_low", {31'b0, cpu_stall}, 32'd0);
    cyc = 1;
    while (!dev_ack && !cpu_ack && cyc < 20) begin tick(); cyc++; end
    check("flush_dev_first", {30'b0, cpu_ack, dev_ack}, 32'd1);
    check("flush_dev_latency", cyc, 3);
    sb_q.push_back({1'b0, 4'b1111, 32'h0000_7000, 32'h7777_0000});
    tick();
    dev_req = 0; cpu_flush = 0;
    #1;
    check("unflush_stall_high", {31'b0, cpu_stall}, 32'd1);
    cyc = 1;
    while (!cpu_ack && cyc < 20) begin tick(); cyc++; end
    check("unflush_cpu_latency", cyc, 3);
    tick();
    cpu_req = 0;

    // Flush raised during ISSUE of a CPU write.
    sb_q.push_back({1'b0, 4'b1111, 32'h0000_8000, 32'h1234_5678});
    cpu_req = 1; cpu_byteen = 4'b1111; cpu_addr = 32'h0000_8000; cpu_wdata = 32'h1234_5678;
    tick();
    cpu_flush = 1;
    #1;
    check("issue_flush_mem_en", {31'b0, mem_en}, 32'd1);
    check("issue_flush_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    check("issue_flush_ack", {31'b0, cpu_ack}, 32'd1);
    tick();
    cpu_req = 0; cpu_flush = 0;

    // Reset during WAIT of a device read.
    sb_q.push_back({1'b1, 4'b0000, 32'h0000_1004, 32'h0});
    dev_req = 1; dev_byteen = 4'b0000; dev_addr = 32'h0000_1004; dev_wdata = 32'h0;
    tick();
    tick();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mem_en", {31'b0, mem_en}, 32'd0);
    check("midrst_dev_ack", {31'b0, dev_ack}, 32'd0);
    mdl_cpu_rdata = '0;
    mdl_dev_rdata = '0;
    reset = 0;
    dev_req = 0;
    tick();
    tick();
    do_xfer('{1'b1, 4'b0000, 32'h0000_1004, 32'h0, 32'h5566_BEEF, 6}, "post_rst");

    tick();
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU M-stage load/store path and a secondary device master (UART loader / debug DMA).
- Sits between the M stage and the data memory. It replaces the direct M_ALURe/M_Byteen/M_TransformStoreData → memory connection.
- Sequences each transfer through issue, read-latency wait and response.
- Raises a stall to the pipeline while the CPU access is outstanding.
- Uses CPU-priority arbitration with a starvation guard for the device.

Parameters:
RD_LAT, 1, memory read latency in cycles (mem_rdata valid RD_LAT cycles after the mem_en cycle); legal range 1..7
STARVE_MAX, 4, consecutive CPU wins while dev_req is pending before the device is forced to win; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held with stable fields until cpu_ack
cpu_byteen  input  4  byte enables; nonzero = write, 0000 = read
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data (already lane-shifted)
cpu_flush  input  1  exception/interrupt flush; masks cpu_req at arbitration
cpu_rdata  output  32  read data, valid while cpu_ack
cpu_ack  output  1  one-cycle completion pulse
cpu_stall  output  1  freezes pipeline: cpu_req & ~cpu_ack & ~cpu_flush (combinational)
dev_req  input  1  device request; held with stable fields until dev_ack
dev_byteen  input  4  as cpu_byteen
dev_addr  input  32  byte address
dev_wdata  input  32  write data
dev_rdata  output  32  read data, valid while dev_ack
dev_ack  output  1  one-cycle completion pulse
mem_en  output  1  memory access strobe, one cycle per transfer
mem_byteen  output  4  registered byte enables
mem_addr  output  32  registered address
mem_wdata  output  32  registered write data
mem_rdata  input  32  memory read data
busy  output  1  transfer in progress (state != IDLE)
owner  output  1  0 = CPU, 1 = device; meaningful while busy

Behaviour:
- The block uses one clock and an asynchronous, active-high reset.
- Reset values:
  - state = IDLE.
  - All outputs = 0: mem_*, *_ack, *_rdata, busy, owner.
  - starve_cnt = 0, wait_cnt = 0.
  - cpu_stall follows its combinational formula.
- State machine states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Candidate set: c = cpu_req & ~cpu_flush, d = dev_req.
  - Winner: device if d & (~c | starve_cnt == STARVE_MAX); else CPU if c; else stay IDLE.
  - On a win, at the edge: latch the winner's byteen/addr/wdata into mem_*, set owner, go to ISSUE.
  - starve_cnt: +1 (saturating at STARVE_MAX) when CPU wins with d high; 0 when the device wins or d is low.
- ISSUE (exactly 1 cycle): mem_en = 1.
  - Next state is RESP if mem_byteen != 0 (write).
  - Otherwise next state is WAIT with wait_cnt = RD_LAT-1.
- WAIT:
  - Decrement wait_cnt each cycle.
  - In the cycle with wait_cnt == 0, capture mem_rdata into the owner's rdata register and go to RESP.
  - The non-owner's rdata is unchanged.
- RESP (1 cycle): owner's ack = 1, then IDLE unconditionally.
  - A request still high during RESP is not re-arbitrated until the following IDLE cycle.
- Latency from IDLE win: write = 3 cycles (win, ISSUE, RESP); read = 3 + RD_LAT cycles.
- Back-to-back transfers: minimum one IDLE cycle between transfers.
- mem_* and rdata registers hold their values outside of updates. mem_en is 0 in every state except ISSUE.
- cpu_flush:
  - Affects only IDLE arbitration and cpu_stall.
  - A CPU transfer already past IDLE completes to memory and still pulses cpu_ack.
- Simultaneous requests: CPU wins unless starve_cnt == STARVE_MAX.
- Requests changing fields mid-transfer: the fields were latched in IDLE, so later changes are ignored.
- Reset asserted mid-transfer: immediate return to IDLE, no ack, mem_en drops asynchronously, the transfer is lost.
- A requester must not deassert req before its ack. If it does, the transfer still completes and acks.

Test Plan:
- After reset with RD_LAT=1: cpu_req write, addr 0x0000_1004, byteen 1111, wdata 0xDEADBEEF → mem_en high in cycle 2 with those values, cpu_ack in cycle 3, cpu_stall high in cycles 1–2.
- CPU read of 0x1004 with memory returning 0xDEADBEEF, RD_LAT=3 → mem_en in cycle 2, cpu_ack in cycle 6, cpu_rdata = 0xDEADBEEF, dev_rdata still 0.
- cpu_req and dev_req held continuously, STARVE_MAX=4, writes only → grant order CPU,CPU,CPU,CPU,DEV,CPU,… and owner matches each mem_en.
- Simultaneous requests with cpu_flush=1 → device wins first, cpu_stall = 0 while flush is high.
- Reset pulse during WAIT of a device read → busy=0, mem_en=0 and dev_ack=0 immediately; the next request is serviced normally.
- cpu_flush raised during ISSUE of a CPU write → mem_en still asserted, cpu_ack still pulses in RESP.
